// File: rtl/hockey_pkg.sv
// Shared definitions for the air-hockey blocks: state encoding, paddle speeds
// and home positions used by the motion units.
package hockey_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SERVE = 3'd1,
      ST_PLAY  = 3'd2,
      ST_GOAL  = 3'd3,
      ST_OVER  = 3'd4
   } state_e;

   localparam logic [5:0] SPEED_SLOW = 6'd1;
   localparam logic [5:0] SPEED_FAST = 6'd5;

   localparam int HOME_X0 = 160;
   localparam int HOME_X1 = 480;
   localparam int HOME_Y  = 240;

   // Paddle step selected by the fast/slow mode bit.
   function automatic logic [5:0] speed_sel(input logic fast);
      return fast ? SPEED_FAST : SPEED_SLOW;
   endfunction

endpackage

// File: rtl/hockey_match_ctrl_frame_tick_gen.sv
// Free-running frame divider: one-cycle tick every TICK_DIV clocks.
// Shared by the match controller, puck and display blocks.
module frame_tick_gen
   import hockey_pkg::*;
#(
   parameter int TICK_DIV = 416667
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int               CNT_W    = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: wrap to zero after the last cycle of the frame.
   always_comb begin
      if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Divider register.
   // NOTE: reset is sampled on the clock edge, so it lives inside the clocked block rather than the sensitivity list.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/hockey_match_ctrl.sv
// Match sequencer for the two-player air-hockey game: game state, run/hold
// level, per-frame move strobe, paddle speed latch, scores and winner.
module hockey_match_ctrl
   import hockey_pkg::*;
#(
   parameter int TICK_DIV        = 416667,
   parameter int SERVE_TICKS     = 60,
   parameter int GOAL_HOLD_TICKS = 120,
   parameter int WIN_SCORE       = 7,
   parameter int SCORE_W         = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [1:0]         mode,
   input  logic               goal_p0,
   input  logic               goal_p1,
   output logic               run,
   output logic               move_tick,
   output logic [5:0]         speed,
   output logic [SCORE_W-1:0] score_p0,
   output logic [SCORE_W-1:0] score_p1,
   output logic               game_over,
   output logic               winner,
   output logic [2:0]         state_dbg
);

   localparam int                 HOLD_MAX = (SERVE_TICKS > GOAL_HOLD_TICKS) ? SERVE_TICKS : GOAL_HOLD_TICKS;
   localparam int                 HOLD_W   = $clog2(HOLD_MAX + 1);
   localparam logic [SCORE_W-1:0] WIN_V    = SCORE_W'(WIN_SCORE);

   logic               frame_tick;
   logic               start_rise;
   logic               mode_unused;
   logic [HOLD_W-1:0]  hold_inc;

   state_e             state_q,     state_d;
   logic [HOLD_W-1:0]  hold_q,      hold_d;
   logic [SCORE_W-1:0] score_p0_q,  score_p0_d;
   logic [SCORE_W-1:0] score_p1_q,  score_p1_d;
   logic               winner_q,    winner_d;
   logic [5:0]         speed_q,     speed_d;
   logic               start_q;
   logic               run_q;
   logic               move_tick_q;
   logic               game_over_q;

   // Only mode[1] selects speed; mode[0] is reserved.
   assign mode_unused = mode[0];

   frame_tick_gen #(.TICK_DIV(TICK_DIV)) u_frame_tick_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (frame_tick)
   );

   assign start_rise = start & ~start_q;
   assign hold_inc   = (int'(hold_q) < HOLD_MAX) ? hold_q + HOLD_W'(1) : hold_q;

   // Next-state, hold counter, score and speed-latch decisions.
   // NOTE: every _d gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d    = state_q;
      hold_d     = hold_q;
      score_p0_d = score_p0_q;
      score_p1_d = score_p1_q;
      winner_d   = winner_q;
      speed_d    = speed_q;

      unique case (state_q)
         ST_IDLE: begin
            if (start_rise) begin
               state_d = ST_SERVE;
               hold_d  = '0;
               speed_d = speed_sel(mode[1]);
            end
         end
         ST_SERVE: begin
            if (frame_tick) begin
               if (int'(hold_q) + 1 >= SERVE_TICKS) begin
                  state_d = ST_PLAY;
                  hold_d  = '0;
               end else begin
                  hold_d = hold_inc;
               end
            end
         end
         ST_PLAY: begin
            if (goal_p0 && goal_p1) begin
               // Simultaneous goals: faceoff, nobody scores.
               state_d = ST_GOAL;
               hold_d  = '0;
            end else if (goal_p0) begin
               if (score_p0_q < WIN_V) score_p0_d = score_p0_q + SCORE_W'(1);
               hold_d = '0;
               if (score_p0_d == WIN_V) begin
                  state_d  = ST_OVER;
                  winner_d = 1'b0;
               end else begin
                  state_d = ST_GOAL;
               end
            end else if (goal_p1) begin
               if (score_p1_q < WIN_V) score_p1_d = score_p1_q + SCORE_W'(1);
               hold_d = '0;
               if (score_p1_d == WIN_V) begin
                  state_d  = ST_OVER;
                  winner_d = 1'b1;
               end else begin
                  state_d = ST_GOAL;
               end
            end
         end
         ST_GOAL: begin
            if (frame_tick) begin
               if (int'(hold_q) + 1 >= GOAL_HOLD_TICKS) begin
                  state_d = ST_SERVE;
                  hold_d  = '0;
                  speed_d = speed_sel(mode[1]);
               end else begin
                  hold_d = hold_inc;
               end
            end
         end
         ST_OVER: begin
            if (start_rise) begin
               state_d    = ST_SERVE;
               hold_d     = '0;
               score_p0_d = '0;
               score_p1_d = '0;
               winner_d   = 1'b0;
               speed_d    = speed_sel(mode[1]);
            end
         end
         default: begin
            state_d = ST_IDLE;
            hold_d  = '0;
         end
      endcase

      // Start switch low wins over everything, including a goal this cycle.
      if (!start) begin
         state_d    = ST_IDLE;
         hold_d     = '0;
         score_p0_d = '0;
         score_p1_d = '0;
         winner_d   = 1'b0;
      end
   end

   // State, counters and registered outputs.
   // NOTE: clocked state uses non-blocking assignments so all flops update from the same pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         hold_q      <= '0;
         score_p0_q  <= '0;
         score_p1_q  <= '0;
         winner_q    <= 1'b0;
         speed_q     <= SPEED_SLOW;
         start_q     <= 1'b0;
         run_q       <= 1'b0;
         move_tick_q <= 1'b0;
         game_over_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         score_p0_q  <= score_p0_d;
         score_p1_q  <= score_p1_d;
         winner_q    <= winner_d;
         speed_q     <= speed_d;
         start_q     <= start;
         run_q       <= (state_d == ST_PLAY);
         move_tick_q <= frame_tick && (state_q == ST_PLAY);
         game_over_q <= (state_d == ST_OVER);
      end
   end

   assign run       = run_q;
   assign move_tick = move_tick_q;
   assign speed     = speed_q;
   assign score_p0  = score_p0_q;
   assign score_p1  = score_p1_q;
   assign game_over = game_over_q;
   assign winner    = winner_q;
   assign state_dbg = state_q;

endmodule
